// File: rtl/spi_flash_responder_pkg.sv
// Shared types and constants for the SPI flash read responder.
// Holds the FSM state encoding, the supported command and the frame bit lengths.
package spi_flash_responder_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        FETCH,
        DATA,
        IGNORE
    } state_t;

    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [4:0] CMD_BITS  = 5'd8;
    localparam logic [4:0] ADDR_BITS = 5'd24;

    // Little-endian lane pick: byte offset 0 is the least significant byte of the word.
    function automatic logic [7:0] selectByte(input logic [31:0] word, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Multi-flop synchroniser for one asynchronous SPI line plus change detection.
// o_toggle pulses for one clk whenever the synchronised level changes.
module spi_edge_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic i_async,
    output logic o_level,
    output logic o_toggle
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= {STAGES{RESET_VAL}};
            r_prev <= RESET_VAL;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_async};
            r_prev <= r_sync[STAGES-1];
        end
    end

    assign o_level  = r_sync[STAGES-1];
    assign o_toggle = r_sync[STAGES-1] ^ r_prev;

endmodule

// File: rtl/spi_flash_responder.sv
// SPI mode-0 responder for the 0x03 READ command, backed by a 32-bit word memory.
// Streams bytes little-endian from each fetched word, refetching on word boundaries.
module spi_flash_responder
    import spi_flash_responder_pkg::*;
#(
    parameter int ADDR_W      = 20,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sck,
    input  logic              cs_n,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rstrb,
    input  logic [31:0]       mem_rdata,
    output logic              busy,
    output logic              cmd_err
);

    localparam int BA_W = ADDR_W + 2;

    state_t              r_state;
    state_t              w_stateNext;
    logic [4:0]          r_bitCnt;
    logic [BA_W-2:0]     r_shiftIn;
    logic [BA_W-1:0]     r_byteAddr;
    logic [31:0]         r_word;
    logic [7:0]          r_shiftOut;
    logic                r_misoBit;
    logic                r_streaming;
    logic [ADDR_W-1:0]   r_memAddr;
    logic                r_memRstrb;
    logic                r_cmdErr;
    logic [SYNC_STAGES-1:0] r_mosiSync;

    logic                w_sckLevel;
    logic                w_sckToggle;
    logic                w_csLevel;
    logic                w_csToggle;
    logic                w_mosi;
    logic                w_sckRise;
    logic                w_sckFall;
    logic                w_csRise;
    logic                w_csFall;
    logic [BA_W-1:0]     w_shiftInNext;
    logic [BA_W-1:0]     w_byteAddrInc;
    logic                w_cmdDone;
    logic                w_addrDone;
    logic                w_byteDone;

    spi_edge_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sckSync (
        .clk      (clk),
        .reset    (reset),
        .i_async  (sck),
        .o_level  (w_sckLevel),
        .o_toggle (w_sckToggle)
    );

    spi_edge_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_csSync (
        .clk      (clk),
        .reset    (reset),
        .i_async  (cs_n),
        .o_level  (w_csLevel),
        .o_toggle (w_csToggle)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mosiSync <= '0;
        end else begin
            r_mosiSync <= {r_mosiSync[SYNC_STAGES-2:0], mosi};
        end
    end

    // sck edges only count while the synchronised select is low.
    assign w_mosi        = r_mosiSync[SYNC_STAGES-1];
    assign w_sckRise     = w_sckToggle &  w_sckLevel & ~w_csLevel;
    assign w_sckFall     = w_sckToggle & ~w_sckLevel & ~w_csLevel;
    assign w_csRise      = w_csToggle  &  w_csLevel;
    assign w_csFall      = w_csToggle  & ~w_csLevel;
    assign w_shiftInNext = {r_shiftIn, w_mosi};
    assign w_byteAddrInc = r_byteAddr + 1'b1;
    assign w_cmdDone     = (r_state == CMD)  && w_sckRise && (r_bitCnt == CMD_BITS - 5'd1);
    assign w_addrDone    = (r_state == ADDR) && w_sckRise && (r_bitCnt == ADDR_BITS - 5'd1);
    assign w_byteDone    = (r_state == DATA) && w_sckFall && (r_bitCnt == 5'd7);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        busy        = (r_state != IDLE);
        miso_oe     = (r_state == DATA) || ((r_state == FETCH) && r_streaming);
        miso        = r_misoBit & miso_oe;
        if (w_csRise) begin
            w_stateNext = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (w_csFall) w_stateNext = CMD;
                CMD:     if (w_cmdDone) w_stateNext = (w_shiftInNext[7:0] == CMD_READ) ? ADDR : IGNORE;
                ADDR:    if (w_addrDone) w_stateNext = FETCH;
                FETCH:   if (!r_memRstrb) w_stateNext = DATA;
                DATA:    if (w_byteDone && (w_byteAddrInc[1:0] == 2'b00)) w_stateNext = FETCH;
                IGNORE:  w_stateNext = IGNORE;
                default: w_stateNext = IDLE;
            endcase
        end
    end

    // The strobe is raised on entry to FETCH; the word is captured the cycle after it drops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bitCnt    <= '0;
            r_shiftIn   <= '0;
            r_byteAddr  <= '0;
            r_word      <= '0;
            r_shiftOut  <= '0;
            r_misoBit   <= 1'b0;
            r_streaming <= 1'b0;
            r_memAddr   <= '0;
            r_memRstrb  <= 1'b0;
            r_cmdErr    <= 1'b0;
        end else begin
            r_memRstrb <= 1'b0;
            r_cmdErr   <= 1'b0;
            if (w_csRise) begin
                r_bitCnt    <= '0;
                r_shiftIn   <= '0;
                r_shiftOut  <= '0;
                r_misoBit   <= 1'b0;
                r_streaming <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_csFall) begin
                            r_bitCnt  <= '0;
                            r_shiftIn <= '0;
                        end
                    end
                    CMD: begin
                        if (w_sckRise) begin
                            r_shiftIn <= w_shiftInNext[BA_W-2:0];
                            if (w_cmdDone) begin
                                r_bitCnt <= '0;
                                r_cmdErr <= (w_shiftInNext[7:0] != CMD_READ);
                            end else begin
                                r_bitCnt <= r_bitCnt + 5'd1;
                            end
                        end
                    end
                    ADDR: begin
                        if (w_sckRise) begin
                            r_shiftIn <= w_shiftInNext[BA_W-2:0];
                            if (w_addrDone) begin
                                r_bitCnt   <= '0;
                                r_byteAddr <= w_shiftInNext;
                                r_memAddr  <= w_shiftInNext[BA_W-1:2];
                                r_memRstrb <= 1'b1;
                            end else begin
                                r_bitCnt <= r_bitCnt + 5'd1;
                            end
                        end
                    end
                    FETCH: begin
                        if (!r_memRstrb) begin
                            r_word      <= mem_rdata;
                            r_shiftOut  <= selectByte(mem_rdata, r_byteAddr[1:0]);
                            r_streaming <= 1'b1;
                        end
                    end
                    DATA: begin
                        if (w_sckFall) begin
                            r_misoBit <= r_shiftOut[7];
                            if (w_byteDone) begin
                                r_bitCnt   <= '0;
                                r_byteAddr <= w_byteAddrInc;
                                if (w_byteAddrInc[1:0] == 2'b00) begin
                                    r_memAddr  <= w_byteAddrInc[BA_W-1:2];
                                    r_memRstrb <= 1'b1;
                                end else begin
                                    r_shiftOut <= selectByte(r_word, w_byteAddrInc[1:0]);
                                end
                            end else begin
                                r_shiftOut <= {r_shiftOut[6:0], 1'b0};
                                r_bitCnt   <= r_bitCnt + 5'd1;
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign mem_addr  = r_memAddr;
    assign mem_rstrb = r_memRstrb;
    assign cmd_err   = r_cmdErr;

endmodule

// File: doc/spi_flash_responder.md
SPI_FLASH_RESPONDER -- requirements
Module: spi_flash_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 20, word-address width of the backing memory.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchroniser depth for sck/cs_n/mosi.
REQ-003 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port sck  input  1  SPI clock from the initiator, asynchronous to clk.
REQ-006 SHALL have port cs_n  input  1  SPI chip select, active low.
REQ-007 SHALL have port mosi  input  1  serial command/address from the initiator.
REQ-008 SHALL have port miso  output  1  serial read data to the initiator.
REQ-009 SHALL have port miso_oe  output  1  high only while data is driven.
REQ-010 SHALL have port mem_addr  output  ADDR_W  word address to the backing memory.
REQ-011 SHALL have port mem_rstrb  output  1  one-cycle read strobe.
REQ-012 SHALL have port mem_rdata  input  32  word from memory, valid exactly 1 clk after mem_rstrb.
REQ-013 SHALL have port busy  output  1  high while a transaction is selected.
REQ-014 SHALL have port cmd_err  output  1  one-cycle pulse on an unsupported command.

Function
REQ-015 SHALL synchronise sck, cs_n, mosi through SYNC_STAGES flops; sck edges detected from the synchronised value; operation guaranteed for sck period >= 8 clk.
REQ-016 SHALL implement SPI mode 0: mosi sampled on sck rising edge; miso updated on sck falling edge; MSB first.
REQ-017 SHALL use states IDLE, CMD, ADDR, FETCH, DATA, IGNORE.
REQ-018 IDLE -> CMD on synchronised cs_n falling; bit counter cleared; busy=1.
REQ-019 CMD: shift 8 bits; after 8th bit, 0x03 -> ADDR, any other value -> IGNORE with cmd_err pulsed 1 cycle.
REQ-020 ADDR: shift 24-bit byte address; after 24th bit -> FETCH.
REQ-021 FETCH: mem_addr = byte_addr[ADDR_W+1:2], mem_rstrb=1 for 1 clk, capture mem_rdata next clk, load byte byte_addr[1:0] into output shift register -> DATA; total <= 3 clk after the 24th-bit edge is detected.
REQ-022 Byte selection little-endian: byte_addr[1:0]=0 -> mem_rdata[7:0], 3 -> mem_rdata[31:24].
REQ-023 DATA: miso_oe=1; first bit (bit 7) driven on the first sck falling edge after the last address bit; subsequent bits on each falling edge.
REQ-024 After the 8th bit of a byte, byte_addr increments; next byte taken from the held word; when byte_addr[1:0] wraps to 0, a new fetch (mem_rstrb) issues within 1 clk of the last falling edge, completing before the next falling edge.
REQ-025 byte_addr wraps modulo 2^(ADDR_W+2); bits above ADDR_W+1 ignored.
REQ-026 Transaction length unlimited; data streams until cs_n rises.
REQ-027 IGNORE: mosi/sck ignored, miso_oe=0, until cs_n rises.
REQ-028 cs_n rising in any state -> IDLE next clk; partial byte discarded; busy=0, miso_oe=0; an in-flight fetch result is dropped.
REQ-029 miso SHALL be 0 whenever miso_oe=0.
REQ-030 sck edges while cs_n high SHALL be ignored.

Reset
REQ-031 On reset: state IDLE; miso=0, miso_oe=0, mem_rstrb=0, mem_addr=0, busy=0, cmd_err=0; counters/shift registers cleared; synchronisers set to sck=0, cs_n=1, mosi=0.
REQ-032 Reset asserted mid-transaction SHALL abort it; after release, the block waits for a fresh cs_n falling edge.

Structure
REQ-033 Shared package SHALL hold the state enum, CMD_READ=8'h03, and the 8/24 command/address bit-length constants.
REQ-034 One sub-module spi_edge_sync (synchroniser plus rise/fall detect) SHALL be instantiated for sck and reused for cs_n.

Verification
REQ-035 Memory word0=0x44332211, cmd 0x03, addr 0x000000, read 4 bytes -> miso bytes 0x11,0x22,0x33,0x44; one mem_rstrb, mem_addr=0.
REQ-036 addr 0x000003, read 3 bytes, word0=0x44332211, word1=0x88776655 -> 0x44,0x55,0x66; second mem_rstrb with mem_addr=1.
REQ-037 cmd 0x9F -> cmd_err pulses once, miso_oe stays 0, no mem_rstrb until cs_n rises.
REQ-038 cs_n raised after 13 data bits -> IDLE within SYNC_STAGES+1 clk, miso_oe=0; next 0x03 transaction at addr 0x000000 returns 0x11.
REQ-039 addr 0x3FFFFF (ADDR_W=20), read 2 bytes -> mem_addr 0xFFFFF then 0x00000.
REQ-040 reset pulsed mid-ADDR -> all outputs at reset values; later 0x03 transaction completes correctly.
